// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two halfadders + OR) and a
// carry flop process the operands LSB-first, one bit per clock.

module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// Handshake: start is sampled only in IDLE; busy is high for the WIDTH ADD
// cycles; done pulses for one cycle, from which sum/cout are valid and held.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_p;
  logic             w_g;
  logic             w_s;
  logic             w_pc;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_res_next;

  halfadder u_ha0 (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .sum   (w_p),
    .carry (w_g)
  );

  halfadder u_ha1 (
    .a     (w_p),
    .b     (r_carry),
    .sum   (w_s),
    .carry (w_pc)
  );

  assign w_carry_next = w_g | w_pc;
  assign w_res_next   = {w_s, r_res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_next;
          r_carry  <= w_carry_next;
          r_cnt    <= r_cnt + CW'(1);
          // The last bit lands in the result on this same edge.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_sum   <= w_res_next;
            r_cout  <= w_carry_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule
